fifo_read_drain: RTL and testbench

// - Read-side consumer for the FIFO. Watches the FIFO's empty flag and issues single-cycle read pulses.
// - Waits out the FIFO/RAM read latency, then captures rd_data into an output register.
// - Presents each word downstream on a valid/ready interface; out_last marks every BURST-th word.
// - Exactly one read is outstanding at a time. This block is the FIFO's sole reader.

---
 rtl/fifo_read_drain.sv | 116 +++++++++++
 tb/tb_fifo_read_drain.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_drain.sv
// Read-side FIFO consumer: issues single read pulses, waits out RAM latency,
// captures the word and presents it on a valid/ready port with burst markers.
module fifo_read_drain #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned BURST      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             empty,
   input  logic [WIDTH-1:0] rd_data,
   output logic             read,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [15:0]      words_sent
);

   localparam int unsigned LAT_W    = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
   localparam int unsigned LAT_LAST = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
   localparam int unsigned BURST_W  = (BURST > 1) ? $clog2(BURST) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_CAP,
      S_HOLD
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic                 w_capture;
   logic                 w_handshake;
   logic [LAT_W-1:0]     r_lat;
   logic [BURST_W-1:0]   r_burst;
   logic                 r_read;
   logic [WIDTH-1:0]     r_out_data;
   logic                 r_out_valid;
   logic                 r_out_last;
   logic [15:0]          r_words_sent;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state and datapath strobes; empty is only consulted at decision points
   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_handshake  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable && !empty) w_state_next = S_REQ;
         end
         S_REQ: begin
            w_state_next = (RD_LATENCY > 1) ? S_WAIT : S_CAP;
         end
         S_WAIT: begin
            if (r_lat == LAT_W'(LAT_LAST)) w_state_next = S_CAP;
         end
         S_CAP: begin
            w_capture    = 1'b1;
            w_state_next = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) begin
               w_handshake  = 1'b1;
               w_state_next = (enable && !empty) ? S_REQ : S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // read is registered from the next state so it is high exactly while in REQ
   always_ff @(posedge clk) begin
      if (reset) begin
         r_read       <= 1'b0;
         r_lat        <= '0;
         r_burst      <= '0;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_words_sent <= '0;
      end else begin
         r_read <= (w_state_next == S_REQ);

         if (r_state == S_REQ)       r_lat <= '0;
         else if (r_state == S_WAIT) r_lat <= r_lat + LAT_W'(1);

         if (w_capture) begin
            r_out_data  <= rd_data;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_burst == BURST_W'(BURST - 1));
         end else if (w_handshake) begin
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_words_sent <= r_words_sent + 16'd1;
            if (r_burst == BURST_W'(BURST - 1)) r_burst <= '0;
            else                                r_burst <= r_burst + BURST_W'(1);
         end
      end
   end

   assign read       = r_read;
   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign out_last   = r_out_last;
   assign words_sent = r_words_sent;

endmodule

// File: tb/tb_fifo_read_drain.sv
// Bench for fifo_read_drain: a queue-based FIFO model with read latency and
// an expected-word queue checked at every downstream handshake.
module tb_fifo_read_drain;

   localparam int unsigned WIDTH      = 8;
   localparam int unsigned RD_LATENCY = 2;
   localparam int unsigned BURST      = 4;

   logic             clk;
   logic             reset;
   logic             enable;
   logic             empty;
   logic [WIDTH-1:0] rd_data;
   logic             read;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [15:0]      words_sent;

   fifo_read_drain #(
      .WIDTH      (WIDTH),
      .RD_LATENCY (RD_LATENCY),
      .BURST      (BURST)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .empty      (empty),
      .rd_data    (rd_data),
      .read       (read),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .words_sent (words_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned      n_checks = 0;
   int unsigned      n_pass   = 0;
   int unsigned      cyc      = 0;
   int unsigned      n_reads  = 0;
   int unsigned      n_hs     = 0;
   int unsigned      n_pushed = 0;
   logic [WIDTH-1:0] fifo_q[$];
   logic [WIDTH-1:0] exp_q[$];
   int unsigned      read_cycles[$];
   logic [WIDTH-1:0] pipe;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic load(input logic [WIDTH-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
      n_pushed++;
      empty = 1'b0;
   endtask

   // One clock: FIFO model with RD_LATENCY=2 pipeline, plus handshake scoreboard
   task automatic tick();
      logic             hs, rd, rst, pv, pl;
      logic [WIDTH-1:0] pd, ew;
      hs  = (out_valid === 1'b1) && (out_ready === 1'b1) && !reset;
      rd  = (read === 1'b1);
      rst = reset;
      pv  = (out_valid === 1'b1);
      pd  = out_data;
      pl  = out_last;
      if (rd) check("read_while_empty", 32'(fifo_q.size() != 0), 32'd1);
      @(posedge clk);
      #1;
      cyc++;
      rd_data = pipe;
      pipe    = 8'hEE;
      if (rd) begin
         n_reads++;
         read_cycles.push_back(cyc);
         if (fifo_q.size() != 0) pipe = fifo_q.pop_front();
      end
      empty = (fifo_q.size() == 0);
      if (rst) begin
         n_hs = 0;
      end else if (hs) begin
         ew = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         check("hs_data", 32'(pd), 32'(ew));
         check("hs_last", 32'(pl), 32'((n_hs % BURST) == BURST - 1));
         n_hs++;
         check("words_sent", 32'(words_sent), 32'(16'(n_hs)));
         check("valid_drop", 32'(out_valid), 32'd0);
      end else if (pv) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data", 32'(out_data), 32'(pd));
         check("hold_last", 32'(out_last), 32'(pl));
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      fifo_q.delete();
      exp_q.delete();
      n_pushed = 0;
      empty = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      read_cycles.delete();
   endtask

   task automatic wait_read();
      int unsigned n0;
      int unsigned k;
      n0 = n_reads;
      k  = 0;
      while (n_reads == n0 && k < 50) begin
         tick();
         k++;
      end
      check("wait_read", 32'(n_reads > n0), 32'd1);
   endtask

   task automatic drain();
      int unsigned k;
      k = 0;
      while (exp_q.size() != 0 && k < 1000) begin
         tick();
         k++;
      end
      check("drain_done", 32'(exp_q.size()), 32'd0);
      repeat (3) tick();
      check("drain_idle_valid", 32'(out_valid), 32'd0);
      check("drain_idle_read", 32'(read), 32'd0);
   endtask

   initial begin
      int unsigned r0;
      int unsigned k;
      reset     = 1'b1;
      enable    = 1'b1;
      empty     = 1'b1;
      out_ready = 1'b0;
      rd_data   = '0;
      pipe      = 8'hEE;

      // 1) reset then idle with an empty FIFO
      do_reset();
      repeat (3) tick();
      check("rst_read", 32'(read), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_words", 32'(words_sent), 32'd0);
      check("rst_no_reads", n_reads, 32'd0);

      // 2) single word, always ready
      do_reset();
      out_ready = 1'b1;
      r0 = n_reads;
      load(8'hA5);
      wait_read();
      tick();
      check("s2_cap_valid", 32'(out_valid), 32'd0);
      tick();
      check("s2_valid", 32'(out_valid), 32'd1);
      check("s2_data", 32'(out_data), 32'hA5);
      check("s2_last", 32'(out_last), 32'd0);
      tick();
      check("s2_words", 32'(words_sent), 32'd1);
      repeat (6) tick();
      check("s2_one_read", n_reads - r0, 32'd1);

      // 3) single word with a stalled sink
      do_reset();
      out_ready = 1'b0;
      r0 = n_reads;
      load(8'hA5);
      wait_read();
      tick();
      tick();
      check("s3_valid", 32'(out_valid), 32'd1);
      repeat (5) begin
         tick();
         check("s3_hold_valid", 32'(out_valid), 32'd1);
         check("s3_hold_data", 32'(out_data), 32'hA5);
      end
      check("s3_one_read", n_reads - r0, 32'd1);
      out_ready = 1'b1;
      tick();
      check("s3_hs_valid", 32'(out_valid), 32'd0);
      check("s3_words", 32'(words_sent), 32'd1);

      // 4) eight-word stream, read spacing
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) load(8'(i));
      drain();
      check("s4_reads", 32'(read_cycles.size()), 32'd8);
      for (int i = 1; i < read_cycles.size(); i++)
         check("s4_spacing", read_cycles[i] - read_cycles[i-1], 32'(RD_LATENCY + 2));
      check("s4_words", 32'(words_sent), 32'd8);

      // 5) enable pause during the latency wait of word 2
      do_reset();
      out_ready = 1'b1;
      enable    = 1'b1;
      for (int i = 0; i < 6; i++) load(8'($urandom));
      wait_read();
      wait_read();
      enable = 1'b0;
      r0 = n_reads;
      repeat (10) tick();
      check("s5_no_read_paused", n_reads - r0, 32'd0);
      check("s5_word2_done", 32'(words_sent), 32'd2);
      enable = 1'b1;
      drain();
      check("s5_words", 32'(words_sent), 32'd6);

      // 6) reset while word 3 is held
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) load(8'($urandom));
      k = 0;
      while (!(n_hs == 2 && out_valid === 1'b1) && k < 100) begin
         tick();
         k++;
      end
      check("s6_reach_hold3", 32'(n_hs == 2 && out_valid === 1'b1), 32'd1);
      out_ready = 1'b0;
      reset     = 1'b1;
      void'(exp_q.pop_front());
      tick();
      check("s6_rst_valid", 32'(out_valid), 32'd0);
      check("s6_rst_words", 32'(words_sent), 32'd0);
      check("s6_rst_read", 32'(read), 32'd0);
      reset     = 1'b0;
      out_ready = 1'b1;
      load(8'($urandom));
      drain();
      check("s6_words", 32'(words_sent), 32'd4);

      // 7) random traffic with random enable and sink stalls
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (n_pushed < 40 && ($urandom % 3) == 0) load(8'($urandom));
         enable    = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         tick();
      end
      while (n_pushed < 40) load(8'($urandom));
      enable    = 1'b1;
      out_ready = 1'b1;
      drain();
      check("s7_words", 32'(words_sent), 32'd40);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
